obi_manager_be: RTL and testbench

- OBI v1.x byte-enabled manager: the initiating end of the OBI link to the team's byte-enabled SRAM subordinates.
- Accepts one command from a local client through a valid/ready interface and drives the OBI A channel until granted.
- Collects the R-channel response and returns rdata/err to the client through a second valid/ready interface.
- One outstanding transaction at a time. A saturating counter reports per-transaction latency for bring-up and profiling.

---
 rtl/obi_mgr_pkg.sv | 15 +
 rtl/obi_sat_counter.sv | 21 ++
 rtl/obi_manager_be.sv | 120 ++++++++++++
 tb/tb_obi_manager_be.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/obi_mgr_pkg.sv
// obi_mgr_pkg: shared state encoding and helpers for the byte-enabled OBI manager.
package obi_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } obi_state_e;

    function automatic logic is_active(input obi_state_e s);
        return (s == ADDR) || (s == RESP);
    endfunction

endpackage

// File: rtl/obi_sat_counter.sv
// obi_sat_counter: clearable up-counter that sticks at its all-ones value.
module obi_sat_counter #(
    parameter int unsigned LAT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    output logic [LAT_WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            count_o <= '0;
        else if (clear_i)
            count_o <= '0;
        else if (enable_i && !(&count_o))
            count_o <= count_o + 1'b1;
    end

endmodule

// File: rtl/obi_manager_be.sv
// obi_manager_be: single-outstanding OBI manager bridging a client valid/ready
// command/response pair onto the A and R channels, with per-transaction latency.
module obi_manager_be
    import obi_mgr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LAT_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [LAT_WIDTH-1:0]    rsp_lat_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } a_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    obi_state_e state_q, state_d;
    a_chan_t    a_q;
    rsp_t       rsp_q;
    logic       cmd_ready_q, req_q, rready_q, rsp_valid_q;
    logic       cmd_hs;

    // Handshake only on the registered ready, so nothing is taken in the first cycle after reset.
    assign cmd_hs = cmd_ready_q && cmd_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs)       state_d = ADDR;
            ADDR:    if (obi_gnt_i)    state_d = RESP;
            RESP:    if (obi_rvalid_i) state_d = DONE;
            DONE:    if (rsp_ready_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state to keep them glitch-free Moore outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            a_q         <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == IDLE);
            req_q       <= (state_d == ADDR);
            rready_q    <= (state_d == RESP);
            rsp_valid_q <= (state_d == DONE);
            if (cmd_hs) begin
                a_q.addr  <= cmd_addr_i;
                a_q.we    <= cmd_we_i;
                a_q.be    <= cmd_be_i;
                a_q.wdata <= cmd_we_i ? cmd_wdata_i : '0;
            end
            if (state_q == RESP && obi_rvalid_i) begin
                rsp_q.rdata <= a_q.we ? '0 : obi_rdata_i;
                rsp_q.err   <= obi_err_i;
            end
        end
    end

    // The counter stops once the state leaves RESP, so its value is the frozen latency in DONE.
    obi_sat_counter #(
        .LAT_WIDTH(LAT_WIDTH)
    ) u_lat (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear_i (cmd_hs),
        .enable_i(is_active(state_q)),
        .count_o (rsp_lat_o)
    );

    assign cmd_ready_o  = cmd_ready_q;
    assign obi_req_o    = req_q;
    assign obi_rready_o = rready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign obi_addr_o   = a_q.addr;
    assign obi_we_o     = a_q.we;
    assign obi_be_o     = a_q.be;
    assign obi_wdata_o  = a_q.wdata;
    assign rsp_rdata_o  = rsp_q.rdata;
    assign rsp_err_o    = rsp_q.err;

endmodule

// File: tb/tb_obi_manager_be.sv
// tb_obi_manager_be: directed transactions with a response scoreboard drained by a monitor.
module tb_obi_manager_be;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [3:0]  rsp_lat_o;
    logic        obi_req_o, obi_gnt_i = 1'b0, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i = '0;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0, obi_rready_o, obi_err_i = 1'b0;

    obi_manager_be #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LAT_WIDTH(4)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_lat_o(rsp_lat_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o),
        .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rsp_valid_o && cmd_ready_o) begin
            errors++;
            $display("FAIL ready_valid_overlap: cmd_ready_o=1 while rsp_valid_o=1");
        end
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rdata=%0h err=%0b with nothing expected", rsp_rdata_o, rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_e.rdata));
                check("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
                check("rsp_lat", 64'(rsp_lat_o), 64'(mon_e.lat));
            end
        end
    end

    // gd/rd: grant and rvalid wait cycles; pd: cycles the response is back-pressured.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int gd, input int rd,
                          input logic [31:0] rdata, input logic err, input int pd, input logic spur);
        int          n;
        int          lat;
        logic        ok;
        exp_t        e;
        logic [31:0] wexp;
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wdata;
        tick();
        cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_addr_i = 32'hFFFF_FFFF; cmd_be_i = 4'hF; cmd_wdata_i = 32'h5A5A_5A5A;
        wexp = we ? wdata : 32'h0;
        check("req_rise", 64'(obi_req_o), 64'(1));
        check("a_addr", 64'(obi_addr_o), 64'(addr));
        check("a_we", 64'(obi_we_o), 64'(we));
        check("a_be", 64'(obi_be_o), 64'(be));
        check("a_wdata", 64'(obi_wdata_o), 64'(wexp));
        check("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
        ok = 1'b1;
        for (int i = 0; i < gd; i++) begin
            obi_gnt_i = 1'b0;
            obi_rvalid_i = spur;
            tick();
            ok = ok & obi_req_o & (obi_addr_o == addr) & (obi_we_o == we) & (obi_be_o == be)
                    & (obi_wdata_o == wexp) & !obi_rready_o;
        end
        if (gd > 0) check("a_stable", 64'(ok), 64'(1));
        obi_rvalid_i = 1'b0;
        obi_gnt_i = 1'b1;
        tick();
        obi_gnt_i = 1'b0;
        check("resp_state", 64'({obi_req_o, obi_rready_o}), 64'(2'b01));
        ok = 1'b1;
        for (int i = 0; i < rd; i++) begin
            obi_gnt_i = spur;
            tick();
            ok = ok & !obi_req_o & obi_rready_o & !rsp_valid_o;
        end
        obi_gnt_i = 1'b0;
        if (rd > 0) check("resp_hold", 64'(ok), 64'(1));
        lat = gd + rd + 2;
        e.rdata = we ? 32'h0 : rdata;
        e.err = err;
        e.lat = 4'((lat > 15) ? 15 : lat);
        exp_q.push_back(e);
        obi_rvalid_i = 1'b1; obi_rdata_i = rdata; obi_err_i = err;
        tick();
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0F0F_0F0F; obi_err_i = 1'b0;
        check("rsp_valid_rise", 64'(rsp_valid_o), 64'(1));
        check("rready_drop", 64'(obi_rready_o), 64'(0));
        ok = 1'b1;
        for (int i = 0; i < pd; i++) begin
            tick();
            ok = ok & rsp_valid_o & (rsp_rdata_o == e.rdata) & (rsp_err_o == err)
                    & (rsp_lat_o == e.lat) & !cmd_ready_o;
        end
        if (pd > 0) check("rsp_hold", 64'(ok), 64'(1));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("rsp_drop", 64'(rsp_valid_o), 64'(0));
        check("cmd_ready_back", 64'(cmd_ready_o), 64'(1));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        #1 reset_ni = 1'b0;
        #2;
        check("rst_outputs", 64'({cmd_ready_o, rsp_valid_o, obi_req_o, obi_rready_o, rsp_err_o, obi_we_o}), 64'(0));
        check("rst_data", 64'({obi_addr_o, obi_wdata_o}), 64'(0));
        check("rst_rsp", 64'({rsp_rdata_o, rsp_lat_o, obi_be_o}), 64'(0));
        repeat (2) tick();
        #2 reset_ni = 1'b1;
        obi_rvalid_i = 1'b1;
        obi_gnt_i = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            tick();
            ok = ok & cmd_ready_o & !obi_req_o & !obi_rready_o & !rsp_valid_o;
        end
        obi_rvalid_i = 1'b0;
        obi_gnt_i = 1'b0;
        check("idle_ignores_spurious", 64'(ok), 64'(1));

        do_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0,         0, 0,  32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        do_txn(1'b1, 32'h0000_0024, 4'b0010, 32'h0000_AB00, 4, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
        do_txn(1'b0, 32'h0000_0030, 4'hF, 32'h0,         1, 2,  32'hCAFE_0001, 1'b1, 5, 1'b0);
        do_txn(1'b0, 32'h0000_0034, 4'hF, 32'h0,         0, 30, 32'h7777_0000, 1'b0, 0, 1'b0);
        do_txn(1'b0, 32'h0000_0038, 4'b1100, 32'h0,      2, 2,  32'h0BAD_F00D, 1'b0, 1, 1'b1);
        do_txn(1'b1, 32'h0000_0003, 4'b0000, 32'hFFFF_FFFF, 0, 0, 32'hAAAA_5555, 1'b0, 0, 1'b0);

        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h80; cmd_be_i = 4'hF;
        tick();
        cmd_valid_i = 1'b0;
        check("abort_req_up", 64'(obi_req_o), 64'(1));
        repeat (2) tick();
        reset_ni = 1'b0;
        #1;
        check("abort_req_async", 64'(obi_req_o), 64'(0));
        check("abort_outputs", 64'({cmd_ready_o, rsp_valid_o, obi_rready_o}), 64'(0));
        @(posedge clk_i);
        #3 reset_ni = 1'b1;
        tick();
        check("abort_ready", 64'({cmd_ready_o, obi_req_o, rsp_valid_o}), 64'(3'b100));
        do_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1, 1, 32'h55AA_55AA, 1'b0, 0, 1'b0);

        repeat (5) tick();
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
